// File: rtl/lpc_post_capture_if.sv
// LPC peripheral-bus bundle shared by the back-ends (POST capture, COM).
// The host side drives the cycle qualifiers, address, strobes and write data.
// The back-end returns the window decode and the read-back byte.
interface lpc_post_capture_if;
  logic        lpc_en;
  logic [15:0] lpc_addr;
  logic        io_wren;
  logic        io_rden;
  logic [7:0]  din;
  logic        addr_hit;
  logic [7:0]  dout;

  modport master (
    output lpc_en, lpc_addr, io_wren, io_rden, din,
    input  addr_hit, dout
  );

  modport slave (
    input  lpc_en, lpc_addr, io_wren, io_rden, din,
    output addr_hit, dout
  );
endinterface

// File: rtl/lpc_post_capture.sv
// LPC POST-code capture unit.
// Decodes the I/O window BASE_ADDR..BASE_ADDR+NUM_BYTES-1 and stages one byte per
// host write. A write to the top byte commits the assembled code to postcode and
// pushes it into a first-word-fall-through history FIFO. When the FIFO is full,
// the oldest entry is dropped and overflow is set.
// Optional feature macro: LPC_POST_READBACK_EN. When defined, host reads inside
// the window return the committed postcode byte on dout one clock later. When it
// is undefined, the port is write-only and dout is tied to zero.
module lpc_post_capture #(
  parameter logic [15:0] BASE_ADDR  = 16'h0080,
  parameter int          NUM_BYTES  = 4,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                             lclk,
  input  logic                             lreset_n,
  lpc_post_capture_if.slave                bus,
  output logic [8*NUM_BYTES-1:0]           postcode,
  output logic                             postcode_stb,
  output logic                             fifo_valid,
  input  logic                             fifo_ready,
  output logic [8*NUM_BYTES-1:0]           fifo_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             overflow,
  input  logic                             overflow_clr
);

  localparam int W  = 8 * NUM_BYTES;
  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Window decode: a single subtract makes every out-of-window address,
  // including those below BASE_ADDR, wrap to a large offset.
  logic [15:0]   offset;
  logic          in_window;
  logic [IW-1:0] byte_idx;

  assign offset    = bus.lpc_addr - BASE_ADDR;
  assign in_window = (offset < 16'(NUM_BYTES));
  assign byte_idx  = offset[IW-1:0];

  // A held write strobe must capture only once, so accept on its rising edge.
  logic wr_now;
  logic wr_q;
  logic accept;
  logic commit;

  assign wr_now = bus.lpc_en & bus.io_wren & in_window;
  assign accept = wr_now & ~wr_q;
  assign commit = accept & (byte_idx == IW'(NUM_BYTES - 1));

  // Edge detector for the qualified write strobe.
  always_ff @(posedge lclk or negedge lreset_n) begin
    if (!lreset_n) begin
      wr_q <= 1'b0;
    end else begin
      wr_q <= wr_now;
    end
  end

  // Staging bytes; lower bytes persist across partial codes.
  logic [7:0] staging [NUM_BYTES];

  always_ff @(posedge lclk or negedge lreset_n) begin
    if (!lreset_n) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        staging[k] <= 8'h00;
      end
    end else if (accept) begin
      staging[byte_idx] <= bus.din;
    end
  end

  // Code being committed: the staged bytes with the byte written this cycle merged in.
  logic [W-1:0] merged;

  always_comb begin
    merged = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (accept && (byte_idx == IW'(k))) begin
        merged[8*k +: 8] = bus.din;
      end else begin
        merged[8*k +: 8] = staging[k];
      end
    end
  end

  // Latest committed code and its one-cycle strobe.
  always_ff @(posedge lclk or negedge lreset_n) begin
    if (!lreset_n) begin
      postcode     <= '0;
      postcode_stb <= 1'b0;
    end else begin
      postcode_stb <= commit;
      if (commit) begin
        postcode <= merged;
      end
    end
  end

  // History FIFO control.
  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          full;

  assign push       = commit;
  assign pop        = fifo_valid & fifo_ready;
  assign full       = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_valid = (fifo_count != '0);
  assign fifo_data  = fifo_valid ? mem[rd_ptr] : '0;

  // Pointers, occupancy and the sticky overflow flag. A push into a full FIFO
  // without a pop advances the read pointer, which discards the oldest entry.
  always_ff @(posedge lclk or negedge lreset_n) begin
    if (!lreset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop || (push && full)) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop && !full) begin
        fifo_count <= fifo_count + CW'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CW'(1);
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // FIFO storage needs no reset because fifo_data is masked while empty.
  always_ff @(posedge lclk) begin
    if (push) begin
      mem[wr_ptr] <= merged;
    end
  end

`ifdef LPC_POST_READBACK_EN
  // Read-back: the window also claims reads and returns a committed byte.
  logic [7:0] rd_byte;
  logic [7:0] dout_q;

  assign bus.addr_hit = bus.lpc_en & in_window & (bus.io_wren | bus.io_rden);
  assign bus.dout     = dout_q;

  // Selects the committed byte addressed by the current read.
  always_comb begin
    rd_byte = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (byte_idx == IW'(k)) begin
        rd_byte = postcode[8*k +: 8];
      end
    end
  end

  // Registered read data; reads never disturb the FIFO.
  always_ff @(posedge lclk or negedge lreset_n) begin
    if (!lreset_n) begin
      dout_q <= 8'h00;
    end else if (bus.lpc_en && bus.io_rden && in_window) begin
      dout_q <= rd_byte;
    end
  end
`else
  // Write-only port: only host writes inside the window are claimed.
  assign bus.addr_hit = bus.lpc_en & in_window & bus.io_wren;
  assign bus.dout     = 8'h00;
`endif

endmodule
